fix_value_decoder: RTL
======================

Name: fix_value_decoder

Overview:
- Downstream consumer of the parser top's value read-out port (output_value_o / output_value_valid_o).
- Converts one 256-bit ASCII FIX field value into a binary fixed-point result: unsigned magnitude, sign, and count of fractional digits.
- Processes one character per clock with a small FSM, so a tag lookup returns a number, not text, to the downstream order-handling logic.

Parameters:
- VALUE_WIDTH, 256, width of the ASCII value input; must be a multiple of 8.
- RESULT_WIDTH, 64, width of the binary magnitude output.
- MAX_CHARS, VALUE_WIDTH/8 (32), characters examined per value; derived, not overridden.

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- value_i  input  VALUE_WIDTH  ASCII value. Char 0 (first received) is at [VALUE_WIDTH-1 -: 8], char i is at [VALUE_WIDTH-1-8i -: 8]. Unused trailing bytes are 0x00.
- value_valid_i  input  1  one-cycle strobe; value_i is sampled when this is high.
- busy_o  output  1  high while a value is being decoded; new strobes are ignored while high.
- result_valid_o  output  1  one-cycle pulse; result outputs are valid and stay held until the next pulse.
- int_o  output  RESULT_WIDTH  magnitude, all digits concatenated, with the decimal point removed.
- frac_digits_o  output  6  number of digits after the decimal point.
- neg_o  output  1  value had a leading '-'.
- error_o  output  1  malformed or overflowing value; qualified by result_valid_o.

Behaviour:
- Reset (rst sampled high at a rising edge):
  - FSM goes to IDLE; busy_o=0, result_valid_o=0, int_o=0, frac_digits_o=0, neg_o=0, error_o=0.
  - Shift register, accumulator and char counter are cleared.
  - Reset mid-PARSE or mid-DONE aborts the decode; no result_valid_o pulse is produced.
- IDLE:
  - If value_valid_i=1: load value_i into the shift register, clear accumulator, char counter, frac flag, neg flag and error flag; go to PARSE.
  - busy_o=0.
- PARSE:
  - busy_o=1. Each cycle examine the top byte c, then shift left by 8 and increment the char counter.
  - '0'..'9': acc_next = acc*10 + (c-0x30), computed at RESULT_WIDTH+4 bits.
    - If acc_next >= 2^RESULT_WIDTH: error, go to DONE.
    - Otherwise set the digit-seen flag; if the frac flag is set, increment the frac count.
  - '-' (0x2D): legal only at char 0 (sets neg); anywhere else is an error.
  - '.' (0x2E): first occurrence sets the frac flag; a second occurrence is an error.
  - 0x00 or 0x01 (SOH): terminator, go to DONE.
  - Any other byte: error, go to DONE.
  - After examining char MAX_CHARS-1 without a terminator or error: go to DONE.
  - Terminating with no digit seen (e.g. "", "-", ".") is an error.
- Result update on entry to DONE (registered):
  - Success: int_o=acc, frac_digits_o=frac count, neg_o=neg, error_o=0.
  - Error: int_o=0, frac_digits_o=0, neg_o=0, error_o=1.
- DONE:
  - Single cycle: result_valid_o=1, busy_o=1, then go to IDLE.
- Latency:
  - Strobe in cycle 0, k chars examined (terminator or erroring char included) means PARSE occupies cycles 1..k and result_valid_o is high in cycle k+1.
  - Maximum is 33 cycles.
- value_valid_i while busy_o=1 (PARSE or DONE) is dropped silently with no state change. The earliest next accepted strobe is the cycle after DONE.
- Negative zero ("-0") is legal: int_o=0, neg_o=1.
- Trailing '.' ("12.") is legal: frac_digits_o=0.

Test Plan:
- Reset, then strobe "123.45" followed by 0x00 padding → result_valid_o in cycle 8; int_o=12345, frac_digits_o=2, neg_o=0, error_o=0; busy_o high in cycles 1-8.
- Strobe "-7" → result_valid_o in cycle 4; int_o=7, neg_o=1, frac_digits_o=0. A second strobe in cycle 2 is ignored (exactly one result pulse).
- Strobe "18446744073709551615" → int_o=0xFFFFFFFFFFFFFFFF, error_o=0. Strobe "18446744073709551616" → error_o=1, int_o=0, pulse in cycle 21.
- Error cases, each with error_o=1:
  - "1.2.3" errors at char 3, pulse in cycle 5.
  - "1-2" errors at char 1.
  - "12A" errors at char 2.
  - All-zero value_i (empty) errors, pulse in cycle 2.
- 32 '0' chars with no terminator → pulse in cycle 33, int_o=0, error_o=0. Back-to-back strobe in cycle 34 is accepted.
- Strobe "999" with rst asserted in cycle 2 → no result_valid_o; all outputs 0 from cycle 3. Strobe "5" in cycle 3 → pulse in cycle 6, int_o=5.

Source files
------------

// File: rtl/fix_value_decoder.sv
// Decodes one ASCII FIX field value, one character per clock, into an unsigned
// binary magnitude, a sign flag and a count of fractional digits.
module fix_value_decoder #(
  parameter int VALUE_WIDTH  = 256,
  parameter int RESULT_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [VALUE_WIDTH-1:0]  value_i,
  input  logic                    value_valid_i,
  output logic                    busy_o,
  output logic                    result_valid_o,
  output logic [RESULT_WIDTH-1:0] int_o,
  output logic [5:0]              frac_digits_o,
  output logic                    neg_o,
  output logic                    error_o
);

  localparam int MAX_CHARS = VALUE_WIDTH / 8;
  localparam int CW        = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
  localparam int AW        = RESULT_WIDTH + 4;
  localparam logic [CW-1:0] LAST_CHAR = CW'(MAX_CHARS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PARSE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [VALUE_WIDTH-1:0]  shreg, shreg_next;
  logic [RESULT_WIDTH-1:0] acc, acc_next;
  logic [CW-1:0]           cnt, cnt_next;
  logic [5:0]              frac_cnt, frac_cnt_next;
  logic                    frac_flag, frac_flag_next;
  logic                    neg, neg_next;
  logic                    seen, seen_next;
  logic                    fail, stop, err_final;
  logic [7:0]              ch;
  logic [AW-1:0]           prod;

  // Next-state and datapath decode for the character at the top of the shift register
  always_comb begin
    state_next     = state;
    shreg_next     = shreg;
    acc_next       = acc;
    cnt_next       = cnt;
    frac_cnt_next  = frac_cnt;
    frac_flag_next = frac_flag;
    neg_next       = neg;
    seen_next      = seen;
    fail           = 1'b0;
    stop           = 1'b0;
    err_final      = 1'b0;
    ch             = shreg[VALUE_WIDTH-1 -: 8];
    // Extra 4 bits hold acc*10+9 so overflow past RESULT_WIDTH is visible
    prod           = AW'(acc) * AW'(4'd10) + AW'(ch - 8'h30);
    case (state)
      IDLE: begin
        if (value_valid_i) begin
          state_next     = PARSE;
          shreg_next     = value_i;
          acc_next       = '0;
          cnt_next       = '0;
          frac_cnt_next  = 6'd0;
          frac_flag_next = 1'b0;
          neg_next       = 1'b0;
          seen_next      = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      PARSE: begin
        shreg_next = shreg << 8;
        cnt_next   = cnt + CW'(1);
        if (ch >= 8'h30 && ch <= 8'h39) begin
          if (prod[AW-1:RESULT_WIDTH] != 4'd0) begin
            fail = 1'b1;
          end else begin
            acc_next  = prod[RESULT_WIDTH-1:0];
            seen_next = 1'b1;
            if (frac_flag) begin
              frac_cnt_next = frac_cnt + 6'd1;
            end else begin
              frac_cnt_next = frac_cnt;
            end
          end
        end else if (ch == 8'h2D) begin
          if (cnt == '0) begin
            neg_next = 1'b1;
          end else begin
            fail = 1'b1;
          end
        end else if (ch == 8'h2E) begin
          if (frac_flag) begin
            fail = 1'b1;
          end else begin
            frac_flag_next = 1'b1;
          end
        end else if (ch == 8'h00 || ch == 8'h01) begin
          stop = 1'b1;
        end else begin
          fail = 1'b1;
        end
        if (fail || stop || cnt == LAST_CHAR) begin
          state_next = DONE;
          err_final  = fail || !seen_next;
        end else begin
          state_next = PARSE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, working registers and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      shreg          <= '0;
      acc            <= '0;
      cnt            <= '0;
      frac_cnt       <= 6'd0;
      frac_flag      <= 1'b0;
      neg            <= 1'b0;
      seen           <= 1'b0;
      busy_o         <= 1'b0;
      result_valid_o <= 1'b0;
      int_o          <= '0;
      frac_digits_o  <= 6'd0;
      neg_o          <= 1'b0;
      error_o        <= 1'b0;
    end else begin
      state          <= state_next;
      shreg          <= shreg_next;
      acc            <= acc_next;
      cnt            <= cnt_next;
      frac_cnt       <= frac_cnt_next;
      frac_flag      <= frac_flag_next;
      neg            <= neg_next;
      seen           <= seen_next;
      busy_o         <= (state_next != IDLE);
      result_valid_o <= (state == PARSE) && (state_next == DONE);
      if (state == PARSE && state_next == DONE) begin
        if (err_final) begin
          int_o         <= '0;
          frac_digits_o <= 6'd0;
          neg_o         <= 1'b0;
          error_o       <= 1'b1;
        end else begin
          int_o         <= acc_next;
          frac_digits_o <= frac_cnt_next;
          neg_o         <= neg_next;
          error_o       <= 1'b0;
        end
      end else begin
        int_o         <= int_o;
        frac_digits_o <= frac_digits_o;
        neg_o         <= neg_o;
        error_o       <= error_o;
      end
    end
  end

endmodule
